// File: rtl/decode_ctrl_branch_pkg.sv
// Shared decode definitions for the 16-bit pipeline: opcodes, ALU function and
// branch codes, and the control bundle produced by the decode stage.
package mips_pkg;

    localparam logic [6:0] OP_NOP       = 7'h00;
    localparam logic [6:0] OP_ALU_FIRST = 7'h01;
    localparam logic [6:0] OP_ALU_LAST  = 7'h08;
    localparam logic [6:0] OP_LDM       = 7'h09;
    localparam logic [6:0] OP_IADD      = 7'h0A;
    localparam logic [6:0] OP_LDD       = 7'h10;
    localparam logic [6:0] OP_STD       = 7'h11;
    localparam logic [6:0] OP_PUSH      = 7'h12;
    localparam logic [6:0] OP_POP       = 7'h13;
    localparam logic [6:0] OP_SETC      = 7'h14;
    localparam logic [6:0] OP_JZ        = 7'h20;
    localparam logic [6:0] OP_JN        = 7'h21;
    localparam logic [6:0] OP_JC        = 7'h22;
    localparam logic [6:0] OP_JMP       = 7'h23;

    typedef enum logic [2:0] {
        FN_ADD = 3'b000,
        FN_SUB = 3'b001,
        FN_AND = 3'b010,
        FN_OR  = 3'b011,
        FN_NOT = 3'b100,
        FN_INC = 3'b101,
        FN_DEC = 3'b110,
        FN_MOV = 3'b111
    } func_t;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_Z    = 3'b001,
        BR_N    = 3'b010,
        BR_C    = 3'b011,
        BR_JMP  = 3'b100
    } branch_t;

    typedef struct packed {
        logic    skip_w;
        logic    wr;
        logic    pop;
        logic    push;
        logic    skip_m;
        func_t   func;
        logic    skip_e;
        branch_t branch;
        logic    setc;
        logic    load;
        logic    imm2;
        logic    imm1;
    } ctrl_t;

    // A bubble: nothing written back, no memory access, ALU bypassed.
    localparam ctrl_t CTRL_NOP = '{
        skip_w: 1'b1, wr: 1'b0, pop: 1'b0, push: 1'b0, skip_m: 1'b1,
        func: FN_ADD, skip_e: 1'b1, branch: BR_NONE,
        setc: 1'b0, load: 1'b0, imm2: 1'b0, imm1: 1'b0
    };

endpackage

// File: rtl/decode_ctrl_branch_if.sv
// EX-stage status seen by the decode/branch block: hazard source and flag/branch inputs.
interface decode_ctrl_branch_if #(
    parameter int RW = 3
);
    logic          ex_valid;
    logic          ex_ld;
    logic [RW-1:0] ex_rdst;
    logic [2:0]    ex_branch;
    logic          ex_setc;
    logic          ex_skip;
    logic [2:0]    ex_znc;

    modport master (
        output ex_valid, ex_ld, ex_rdst, ex_branch, ex_setc, ex_skip, ex_znc
    );

    modport slave (
        input ex_valid, ex_ld, ex_rdst, ex_branch, ex_setc, ex_skip, ex_znc
    );
endinterface

// File: rtl/decode_ctrl_branch_flag_reg.sv
// Z/N/C flag register. Reset beats SETC, which beats an ALU flag update.
module flag_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic       setc,
    input  logic       skip,
    input  logic [2:0] znc_in,
    output logic       z,
    output logic       n,
    output logic       c
);
    logic [2:0] flags_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_reg <= 3'b000;
        end else if (valid && setc) begin
            flags_reg[0] <= 1'b1;
        end else if (valid && !skip) begin
            flags_reg <= znc_in;
        end
    end

    assign z = flags_reg[2];
    assign n = flags_reg[1];
    assign c = flags_reg[0];
endmodule

// File: rtl/decode_ctrl_branch.sv
// Decode-stage control generation, load-use stall detection and branch resolution
// for the instruction in EX, with the Z/N/C flags held in flag_reg.
module decode_ctrl_branch
    import mips_pkg::*;
#(
    parameter int OPW = 7,
    parameter int RW  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr_d,
    decode_ctrl_branch_if.slave   ex,
    output logic                  stall_d,
    output logic                  skip_w,
    output logic                  wr,
    output logic                  pop,
    output logic                  push,
    output logic                  skip_m,
    output logic [2:0]            func,
    output logic                  skip_e,
    output logic [2:0]            branch,
    output logic                  setc,
    output logic                  load,
    output logic                  imm2,
    output logic                  imm1,
    output logic                  jump,
    output logic                  z,
    output logic                  n,
    output logic                  c
);
    logic [OPW-1:0] opcode;
    logic [OPW-1:0] op_m1;
    ctrl_t          ctrl;
    logic [1:0]     src_hit;
    logic           take;
    logic           unused_instr;

    assign opcode       = instr_d[OPW-1:0];
    assign unused_instr = ^{instr_d[31:16], instr_d[9:7]};

    always_comb begin
        ctrl  = CTRL_NOP;
        op_m1 = opcode - OPW'(1);
        if (opcode >= OP_ALU_FIRST && opcode <= OP_ALU_LAST) begin
            ctrl.func   = func_t'(op_m1[2:0]);
            ctrl.skip_e = 1'b0;
            ctrl.skip_w = 1'b0;
        end else begin
            case (opcode)
                OP_LDM: begin
                    ctrl.func   = FN_MOV;
                    ctrl.imm1   = 1'b1;
                    ctrl.skip_e = 1'b0;
                    ctrl.skip_w = 1'b0;
                end
                OP_IADD: begin
                    ctrl.func   = FN_ADD;
                    ctrl.imm2   = 1'b1;
                    ctrl.skip_e = 1'b0;
                    ctrl.skip_w = 1'b0;
                end
                OP_LDD: begin
                    ctrl.load   = 1'b1;
                    ctrl.skip_m = 1'b0;
                    ctrl.skip_w = 1'b0;
                end
                OP_STD: begin
                    ctrl.wr     = 1'b1;
                    ctrl.skip_m = 1'b0;
                end
                OP_PUSH: begin
                    ctrl.push   = 1'b1;
                    ctrl.wr     = 1'b1;
                    ctrl.skip_m = 1'b0;
                end
                OP_POP: begin
                    ctrl.pop    = 1'b1;
                    ctrl.load   = 1'b1;
                    ctrl.skip_m = 1'b0;
                    ctrl.skip_w = 1'b0;
                end
                OP_SETC: ctrl.setc   = 1'b1;
                OP_JZ:   ctrl.branch = BR_Z;
                OP_JN:   ctrl.branch = BR_N;
                OP_JC:   ctrl.branch = BR_C;
                OP_JMP:  ctrl.branch = BR_JMP;
                default: ctrl = CTRL_NOP;
            endcase
        end
    end

    assign skip_w = ctrl.skip_w;
    assign wr     = ctrl.wr;
    assign pop    = ctrl.pop;
    assign push   = ctrl.push;
    assign skip_m = ctrl.skip_m;
    assign func   = ctrl.func;
    assign skip_e = ctrl.skip_e;
    assign branch = ctrl.branch;
    assign setc   = ctrl.setc;
    assign load   = ctrl.load;
    assign imm2   = ctrl.imm2;
    assign imm1   = ctrl.imm1;

    // Source fields rsrc1/rsrc2 sit back to back from bit 10; both compared for every opcode.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = (ex.ex_rdst == instr_d[10 + gi*RW +: RW]);
        end
    endgenerate

    always_comb begin
        stall_d = ex.ex_valid & ex.ex_ld & (|src_hit);
    end

    flag_reg u_flag_reg (
        .clk    (clk),
        .rst    (rst),
        .valid  (ex.ex_valid),
        .setc   (ex.ex_setc),
        .skip   (ex.ex_skip),
        .znc_in (ex.ex_znc),
        .z      (z),
        .n      (n),
        .c      (c)
    );

    // Branches see only the committed flags, never the EX instruction's own result.
    always_comb begin
        take = 1'b0;
        case (ex.ex_branch)
            BR_Z:    take = z;
            BR_N:    take = n;
            BR_C:    take = c;
            BR_JMP:  take = 1'b1;
            default: take = 1'b0;
        endcase
        jump = ex.ex_valid & take;
    end

endmodule

// File: tb/tb_decode_ctrl_branch.sv
// Scoreboard bench for decode_ctrl_branch: expectations are queued as stimulus is
// driven and popped when the corresponding outputs are sampled.
module tb_decode_ctrl_branch;

    logic        clk;
    logic        rst;
    logic [31:0] instr_d;
    logic        stall_d, skip_w, wr, pop, push, skip_m, skip_e;
    logic [2:0]  func, branch;
    logic        setc, load, imm2, imm1, jump, z, n, c;

    decode_ctrl_branch_if #(.RW(3)) ex_if ();

    decode_ctrl_branch #(.OPW(7), .RW(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .instr_d (instr_d),
        .ex      (ex_if),
        .stall_d (stall_d),
        .skip_w  (skip_w),
        .wr      (wr),
        .pop     (pop),
        .push    (push),
        .skip_m  (skip_m),
        .func    (func),
        .skip_e  (skip_e),
        .branch  (branch),
        .setc    (setc),
        .load    (load),
        .imm2    (imm2),
        .imm1    (imm1),
        .jump    (jump),
        .z       (z),
        .n       (n),
        .c       (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {stall_d, ctrl[19:4], jump, z, n, c}
    logic [20:0] obs;
    assign obs = {stall_d, skip_w, wr, pop, push, skip_m, func, skip_e, branch,
                  setc, load, imm2, imm1, jump, z, n, c};

    localparam logic [20:0] M_FLAGS = 21'h000007;
    localparam logic [20:0] M_JUMP  = 21'h000008;
    localparam logic [20:0] M_CTRL  = 21'h0FFFF0;
    localparam logic [20:0] M_STALL = 21'h100000;

    typedef struct {
        string       name;
        logic [20:0] exp;
        logic [20:0] mask;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    function automatic logic [20:0] ctl(input logic skw, input logic wr_e, input logic pop_e,
                                        input logic push_e, input logic skm, input logic [2:0] fn,
                                        input logic ske, input logic [2:0] br, input logic setc_e,
                                        input logic load_e, input logic imm2_e, input logic imm1_e);
        return {1'b0, skw, wr_e, pop_e, push_e, skm, fn, ske, br, setc_e, load_e, imm2_e, imm1_e, 4'b0000};
    endfunction

    task automatic push_exp(input string nm, input logic [20:0] e, input logic [20:0] m);
        sb_t s;
        s.name = nm;
        s.exp  = e;
        s.mask = m;
        sb_q.push_back(s);
    endtask

    task automatic set_ex(input logic v, input logic ld, input logic [2:0] rd, input logic [2:0] br,
                          input logic sc, input logic sk, input logic [2:0] znc);
        ex_if.ex_valid  = v;
        ex_if.ex_ld     = ld;
        ex_if.ex_rdst   = rd;
        ex_if.ex_branch = br;
        ex_if.ex_setc   = sc;
        ex_if.ex_skip   = sk;
        ex_if.ex_znc    = znc;
    endtask

    task automatic test_reset();
        sb_t s;
        @(negedge clk);
        rst     = 1'b1;
        instr_d = 32'h0;
        set_ex(1'b1, 1'b0, 3'd0, 3'b001, 1'b0, 1'b0, 3'b111);
        push_exp("reset_flags", 21'h0, M_FLAGS | M_JUMP | M_STALL);
        repeat (2) @(posedge clk);
        @(negedge clk);
        s = sb_q.pop_front();
        checks++;
        $display("txn %s obs=%h", s.name, obs & s.mask);
        if ((obs & s.mask) !== (s.exp & s.mask)) begin
            errors++;
            $display("FAIL %s: got %h expected %h", s.name, obs & s.mask, s.exp & s.mask);
        end
        set_ex(1'b0, 1'b0, 3'd0, 3'b000, 1'b0, 1'b0, 3'b000);
        rst = 1'b0;
    endtask

    task automatic test_decode();
        sb_t         s;
        logic [6:0]  ops  [17];
        logic [20:0] exps [17];
        logic [20:0] nopv;
        nopv = ctl(1,0,0,0,1,3'b000,1,3'b000,0,0,0,0);
        ops  = '{7'h00, 7'h01, 7'h02, 7'h05, 7'h08, 7'h09, 7'h0A, 7'h10, 7'h11,
                 7'h12, 7'h13, 7'h14, 7'h20, 7'h21, 7'h22, 7'h23, 7'h7F};
        exps = '{nopv,
                 ctl(0,0,0,0,1,3'b000,0,3'b000,0,0,0,0),
                 ctl(0,0,0,0,1,3'b001,0,3'b000,0,0,0,0),
                 ctl(0,0,0,0,1,3'b100,0,3'b000,0,0,0,0),
                 ctl(0,0,0,0,1,3'b111,0,3'b000,0,0,0,0),
                 ctl(0,0,0,0,1,3'b111,0,3'b000,0,0,0,1),
                 ctl(0,0,0,0,1,3'b000,0,3'b000,0,0,1,0),
                 ctl(0,0,0,0,0,3'b000,1,3'b000,0,1,0,0),
                 ctl(1,1,0,0,0,3'b000,1,3'b000,0,0,0,0),
                 ctl(1,1,0,1,0,3'b000,1,3'b000,0,0,0,0),
                 ctl(0,0,1,0,0,3'b000,1,3'b000,0,1,0,0),
                 ctl(1,0,0,0,1,3'b000,1,3'b000,1,0,0,0),
                 ctl(1,0,0,0,1,3'b000,1,3'b001,0,0,0,0),
                 ctl(1,0,0,0,1,3'b000,1,3'b010,0,0,0,0),
                 ctl(1,0,0,0,1,3'b000,1,3'b011,0,0,0,0),
                 ctl(1,0,0,0,1,3'b000,1,3'b100,0,0,0,0),
                 nopv};
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            instr_d = $urandom();
            if (i < 17) begin
                instr_d[6:0] = ops[i];
                push_exp($sformatf("decode_op%02h", ops[i]), exps[i], M_CTRL);
            end else if (i == 17) begin
                instr_d[6:0] = 7'h0B;
                push_exp("decode_op0b_unused", nopv, M_CTRL);
            end else begin
                rst = 1'b1;
                instr_d[6:0] = 7'h02;
                push_exp("decode_op02_in_rst", exps[2], M_CTRL);
            end
            #1;
            s = sb_q.pop_front();
            checks++;
            $display("txn %s instr=%h obs=%h", s.name, instr_d, obs & s.mask);
            if ((obs & s.mask) !== (s.exp & s.mask)) begin
                errors++;
                $display("FAIL %s: got %h expected %h", s.name, obs & s.mask, s.exp & s.mask);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        sb_t s;
        // {valid, ld, rdst, rsrc1, rsrc2, expected stall}
        logic [11:0] tbl [7];
        tbl = '{{1'b1, 1'b1, 3'd3, 3'd3, 3'd0, 1'b1},
                {1'b1, 1'b1, 3'd3, 3'd5, 3'd3, 1'b1},
                {1'b1, 1'b1, 3'd3, 3'd5, 3'd6, 1'b0},
                {1'b1, 1'b0, 3'd3, 3'd3, 3'd3, 1'b0},
                {1'b0, 1'b1, 3'd3, 3'd3, 3'd3, 1'b0},
                {1'b1, 1'b1, 3'd0, 3'd0, 3'd7, 1'b1},
                {1'b1, 1'b1, 3'd7, 3'd2, 3'd7, 1'b1}};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            set_ex(tbl[i][11], tbl[i][10], tbl[i][9:7], 3'b000, 1'b0, 1'b1, 3'b111);
            instr_d = {16'h0, tbl[i][3:1], tbl[i][6:4], 3'd2, 7'h01};
            push_exp($sformatf("load_use_%0d", i), {tbl[i][0], 20'h0}, M_STALL);
            #1;
            s = sb_q.pop_front();
            checks++;
            $display("txn %s instr=%h obs=%h", s.name, instr_d, obs & s.mask);
            if ((obs & s.mask) !== (s.exp & s.mask)) begin
                errors++;
                $display("FAIL %s: got %h expected %h", s.name, obs & s.mask, s.exp & s.mask);
            end
        end
        set_ex(1'b0, 1'b0, 3'd0, 3'b000, 1'b0, 1'b0, 3'b000);
    endtask

    task automatic test_flags();
        sb_t s;
        // {setc, skip, valid, znc, expected {z,n,c}} applied back to back
        logic [8:0] tbl [7];
        tbl = '{{1'b0, 1'b0, 1'b1, 3'b100, 3'b100},
                {1'b0, 1'b1, 1'b1, 3'b011, 3'b100},
                {1'b1, 1'b1, 1'b1, 3'b000, 3'b101},
                {1'b0, 1'b0, 1'b0, 3'b010, 3'b101},
                {1'b1, 1'b0, 1'b1, 3'b010, 3'b101},
                {1'b0, 1'b0, 1'b1, 3'b010, 3'b010},
                {1'b0, 1'b0, 1'b1, 3'b100, 3'b100}};
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            set_ex(tbl[i][6], 1'b0, 3'd0, 3'b000, tbl[i][8], tbl[i][7], tbl[i][5:3]);
            push_exp($sformatf("flags_%0d", i), {18'h0, tbl[i][2:0]}, M_FLAGS);
            @(negedge clk);
            s = sb_q.pop_front();
            checks++;
            $display("txn %s obs=%h", s.name, obs & s.mask);
            if ((obs & s.mask) !== (s.exp & s.mask)) begin
                errors++;
                $display("FAIL %s: got %h expected %h", s.name, obs & s.mask, s.exp & s.mask);
            end
        end
        set_ex(1'b0, 1'b0, 3'd0, 3'b000, 1'b0, 1'b0, 3'b000);
    endtask

    task automatic test_branch();
        sb_t s;
        // {valid, branch, expected jump}; flags held at z=1 n=0 c=0
        logic [4:0] tbl [8];
        tbl = '{{1'b1, 3'b001, 1'b1}, {1'b1, 3'b010, 1'b0}, {1'b1, 3'b011, 1'b0},
                {1'b1, 3'b100, 1'b1}, {1'b1, 3'b101, 1'b0}, {1'b1, 3'b000, 1'b0},
                {1'b1, 3'b111, 1'b0}, {1'b0, 3'b100, 1'b0}};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_ex(tbl[i][4], 1'b0, 3'd0, tbl[i][3:1], 1'b0, 1'b1, 3'b011);
            push_exp($sformatf("branch_%0d", i), {17'h0, tbl[i][0], 3'b100}, M_JUMP | M_FLAGS);
            #1;
            s = sb_q.pop_front();
            checks++;
            $display("txn %s br=%b obs=%h", s.name, tbl[i][3:1], obs & s.mask);
            if ((obs & s.mask) !== (s.exp & s.mask)) begin
                errors++;
                $display("FAIL %s: got %h expected %h", s.name, obs & s.mask, s.exp & s.mask);
            end
        end
        // JN while the EX instruction itself produces N: not visible until after the edge.
        @(negedge clk);
        set_ex(1'b1, 1'b0, 3'd0, 3'b010, 1'b0, 1'b0, 3'b010);
        push_exp("branch_own_flags_same_cycle", {17'h0, 1'b0, 3'b100}, M_JUMP | M_FLAGS);
        push_exp("branch_own_flags_next_cycle", {17'h0, 1'b1, 3'b010}, M_JUMP | M_FLAGS);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) #1;
            else begin
                @(posedge clk);
                #1;
                set_ex(1'b1, 1'b0, 3'd0, 3'b010, 1'b0, 1'b1, 3'b010);
                #1;
            end
            s = sb_q.pop_front();
            checks++;
            $display("txn %s obs=%h", s.name, obs & s.mask);
            if ((obs & s.mask) !== (s.exp & s.mask)) begin
                errors++;
                $display("FAIL %s: got %h expected %h", s.name, obs & s.mask, s.exp & s.mask);
            end
        end
        set_ex(1'b0, 1'b0, 3'd0, 3'b000, 1'b0, 1'b0, 3'b000);
    endtask

    task automatic test_simultaneous();
        sb_t s;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            case (i)
                0: begin
                    rst = 1'b0;
                    set_ex(1'b1, 1'b0, 3'd0, 3'b000, 1'b1, 1'b1, 3'b000);
                    push_exp("setc_sets_c", {18'h0, 3'b011}, M_FLAGS);
                end
                1: begin
                    rst = 1'b1;
                    set_ex(1'b1, 1'b0, 3'd0, 3'b000, 1'b1, 1'b0, 3'b111);
                    push_exp("rst_beats_setc", {18'h0, 3'b000}, M_FLAGS);
                end
                default: begin
                    rst = 1'b0;
                    set_ex(1'b1, 1'b1, 3'd3, 3'b100, 1'b0, 1'b1, 3'b000);
                    instr_d = {16'h0, 3'd1, 3'd3, 3'd0, 7'h01};
                    push_exp("stall_and_jump", {1'b1, 16'h0, 1'b1, 3'b000}, M_STALL | M_JUMP | M_FLAGS);
                end
            endcase
            if (i < 2) @(negedge clk);
            else #1;
            s = sb_q.pop_front();
            checks++;
            $display("txn %s obs=%h", s.name, obs & s.mask);
            if ((obs & s.mask) !== (s.exp & s.mask)) begin
                errors++;
                $display("FAIL %s: got %h expected %h", s.name, obs & s.mask, s.exp & s.mask);
            end
        end
        rst = 1'b0;
        set_ex(1'b0, 1'b0, 3'd0, 3'b000, 1'b0, 1'b0, 3'b000);
    endtask

    initial begin
        rst     = 1'b1;
        instr_d = 32'h0;
        set_ex(1'b0, 1'b0, 3'd0, 3'b000, 1'b0, 1'b0, 3'b000);
        test_reset();
        test_decode();
        test_load_use();
        test_flags();
        test_branch();
        test_simultaneous();
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_branch.md
Name: decode_ctrl_branch

Overview:
- Decode-stage and branch-resolution block of the 16-bit 5-stage MIPS-style pipeline.
- Decodes the 7-bit opcode of the instruction in ID into WB/MEM/EX control and source-select signals.
- Detects load-use hazards against the instruction in EX and raises a decode stall.
- Holds the Z/N/C flag register and resolves branches of the instruction in EX into a `jump` request for the PC mux.

Parameters:
- `OPW`, 7, opcode width (`instr_d[OPW-1:0]`).
- `RW`, 3, register-index width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_d`  in  32  ID instruction: opcode [6:0], rdst [9:7], rsrc1 [12:10], rsrc2 [15:13].
- `ex_valid`  in  1  EX slot holds a real (non-dirty) instruction.
- `ex_ld`  in  1  EX instruction reads memory (load/pop).
- `ex_rdst`  in  3  EX destination register.
- `ex_branch`  in  3  EX branch code.
- `ex_setc`  in  1  EX instruction is SETC.
- `ex_skip`  in  1  EX instruction bypasses the ALU.
- `ex_znc`  in  3  ALU flags {z,n,c} of the EX instruction.
- `stall_d`  out  1  hold PC and IF/ID, bubble ID/EX.
- `skip_w`  out  1  no register write-back.
- `wr`, `pop`, `push`, `skip_m`  out  1 each  MEM controls.
- `func`  out  3  ALU function.
- `skip_e`  out  1  ALU bypass.
- `branch`  out  3  branch code.
- `setc`, `load`, `imm2`, `imm1`  out  1 each  ID-source controls.
- `jump`  out  1  take branch target.
- `z`, `n`, `c`  out  1 each  registered flags.

Behaviour:
- **Control (combinational from `instr_d[6:0]`).**
  - Defaults: `skip_w`=`skip_m`=`skip_e`=1, all other outputs 0.
  - `func` codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT, 101 INC, 110 DEC, 111 MOV.
  - 0x00 NOP: defaults.
  - 0x01–0x08: ALU op; `func`=opcode-1, `skip_e`=0, `skip_w`=0.
  - 0x09 LDM: MOV, `imm1`=1, `skip_e`=0, `skip_w`=0.
  - 0x0A IADD: ADD, `imm2`=1, `skip_e`=0, `skip_w`=0.
  - 0x10 LDD: `load`=1, `skip_m`=0, `skip_w`=0.
  - 0x11 STD: `wr`=1, `skip_m`=0.
  - 0x12 PUSH: `push`=1, `wr`=1, `skip_m`=0.
  - 0x13 POP: `pop`=1, `load`=1, `skip_m`=0, `skip_w`=0.
  - 0x14 SETC: `setc`=1.
  - 0x20 JZ `branch`=001; 0x21 JN 010; 0x22 JC 011; 0x23 JMP 100.
  - Any other opcode decodes as NOP.
- **Hazard (combinational).**
  - `stall_d` = `ex_valid` & `ex_ld` & (`ex_rdst`==`instr_d[12:10]` | `ex_rdst`==`instr_d[15:13]`).
  - Both source fields are compared regardless of opcode (conservative stall).
- **Flags (registered, rising `clk`).**
  - `rst`=1 → z=n=c=0; this has priority over all updates.
  - Else, if `ex_valid` & `ex_setc` → c←1; z and n hold.
  - Else, if `ex_valid` & !`ex_skip` → {z,n,c}←`ex_znc`.
  - Otherwise hold.
- **Branch (combinational).** Evaluated from the current registered flags; the EX instruction's own `ex_znc` does not affect the same cycle.
  - `jump` = `ex_valid` & (`ex_branch`==001 & z | ==010 & n | ==011 & c | ==100).
  - `ex_branch` codes 000, 101–111 never jump.
  - Taking a branch does not modify flags.
- `jump` and `stall_d` are independent; both may be 1 in the same cycle, and the pipeline gives `jump` priority.
- All combinational outputs are valid regardless of `rst`; only the flag register resets.

Decomposition:
- Shared package `mips_pkg`: opcode constants, `func` codes, branch codes (BR_NONE, BR_Z, BR_N, BR_C, BR_JMP), and a control-bundle struct.
- One natural sub-module: `flag_reg`, holding the Z/N/C register and its update priority.
- Decode, hazard and branch logic are `always_comb` blocks in the top module.

Test Plan:
- Reset: assert `rst` for 2 cycles with `ex_znc`=111, `ex_valid`=1, `ex_skip`=0 → z=n=c=0; `jump`=0 for `ex_branch`=001.
- Decode sweep: apply opcodes 0x02, 0x09, 0x10, 0x12, 0x7F.
  - 0x02 → `func`=001, `skip_e`=0, `skip_w`=0.
  - 0x09 → `imm1`=1, `func`=111.
  - 0x10 → `load`=1, `skip_m`=0.
  - 0x12 → `push`=1, `wr`=1, `skip_w`=1.
  - 0x7F → all NOP defaults.
- Load-use: `ex_ld`=1, `ex_rdst`=3, `instr_d[12:10]`=3 → `stall_d`=1.
  - Change rsrc2 to 3 and rsrc1 to 5 → `stall_d`=1.
  - Set `ex_ld`=0 or `ex_valid`=0 → `stall_d`=0.
- Flags: cycle 1 `ex_znc`=100 with `ex_skip`=0 → z=1 next cycle.
  - `ex_skip`=1 with `ex_znc`=011 → flags hold 100.
  - SETC → c=1, z=1 held.
- Branch: flags z=1, n=0, c=0.
  - `ex_branch` 001 → `jump`=1; 010 → 0; 100 → 1; 101 → 0.
  - `ex_valid`=0 with 100 → 0.
- Simultaneous: `rst`=1 together with `ex_setc`=1 → c=0 after the edge.
